// File: rtl/nand_gate_unit_pkg.sv
// Shared constants for the NAND cell reference block.
// Register reset values match the NAND of all-zero inputs.
package nand_gate_unit_pkg;

    localparam logic RST_Q        = 1'b1;
    localparam logic RST_MISMATCH = 1'b0;

endpackage

// File: rtl/nand2_c.sv
// NAND2 leaf cell, continuous-assign style.
module nand2_c (
    input  logic i1,
    input  logic i2,
    output logic o
);

    assign o = ~(i1 & i2);

endmodule

// File: rtl/nand2_e.sv
// NAND2 leaf cell, gate-primitive style.
module nand2_e (
    input  logic i1,
    input  logic i2,
    output logic o
);

    nand u_nand (o, i1, i2);

endmodule

// File: rtl/nand3_c.sv
// NAND3 leaf cell, continuous-assign style.
module nand3_c (
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic o
);

    assign o = ~(i1 & i2 & i3);

endmodule

// File: rtl/nand_gate_unit.sv
// NAND cell reference block: combinational and registered gate outputs plus a
// cross-check between the two NAND2 implementations.
module nand_gate_unit
    import nand_gate_unit_pkg::*;
#(
    parameter bit STICKY_MISMATCH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    output logic o2_e,
    output logic o2_c,
    output logic o3_c,
    output logic o2_e_q,
    output logic o2_c_q,
    output logic o3_c_q,
    output logic mismatch
);

    logic r_o2_e_q;
    logic r_o2_c_q;
    logic r_o3_c_q;
    logic r_mismatch;
    logic w_cmp;
    logic w_mismatch_d;

    nand2_e u_nand2_e (
        .i1 (i1),
        .i2 (i2),
        .o  (o2_e)
    );

    nand2_c u_nand2_c (
        .i1 (i1),
        .i2 (i2),
        .o  (o2_c)
    );

    nand3_c u_nand3_c (
        .i1 (i1),
        .i2 (i2),
        .i3 (i3),
        .o  (o3_c)
    );

    // Case-inequality so an X on only one implementation still flags.
    always_comb begin
        w_cmp        = (o2_e !== o2_c);
        w_mismatch_d = w_cmp;
        if (STICKY_MISMATCH) begin
            w_mismatch_d = r_mismatch | w_cmp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_o2_e_q   <= RST_Q;
            r_o2_c_q   <= RST_Q;
            r_o3_c_q   <= RST_Q;
            r_mismatch <= RST_MISMATCH;
        end else begin
            r_o2_e_q   <= o2_e;
            r_o2_c_q   <= o2_c;
            r_o3_c_q   <= o3_c;
            r_mismatch <= w_mismatch_d;
        end
    end

    assign o2_e_q   = r_o2_e_q;
    assign o2_c_q   = r_o2_c_q;
    assign o3_c_q   = r_o3_c_q;
    assign mismatch = r_mismatch;

endmodule

// File: tb/tb_nand_gate_unit.sv
// Directed bench for nand_gate_unit: sticky and non-sticky instances share stimulus.
`timescale 1ns/1ps
module tb_nand_gate_unit;

    logic clk;
    logic rst_n;
    logic i1, i2, i3;
    logic s_o2_e, s_o2_c, s_o3_c, s_o2_e_q, s_o2_c_q, s_o3_c_q, s_mismatch;
    logic n_o2_e, n_o2_c, n_o3_c, n_o2_e_q, n_o2_c_q, n_o3_c_q, n_mismatch;

    int n_tests;
    int n_fail;

    typedef struct {
        logic i1;
        logic i2;
        logic i3;
        logic exp_o2;
        logic exp_o3;
    } vec_t;

    vec_t vecs[8];

    nand_gate_unit #(.STICKY_MISMATCH(1'b1)) dut_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .o2_e     (s_o2_e),
        .o2_c     (s_o2_c),
        .o3_c     (s_o3_c),
        .o2_e_q   (s_o2_e_q),
        .o2_c_q   (s_o2_c_q),
        .o3_c_q   (s_o3_c_q),
        .mismatch (s_mismatch)
    );

    nand_gate_unit #(.STICKY_MISMATCH(1'b0)) dut_n (
        .clk      (clk),
        .rst_n    (rst_n),
        .i1       (i1),
        .i2       (i2),
        .i3       (i3),
        .o2_e     (n_o2_e),
        .o2_c     (n_o2_c),
        .o3_c     (n_o3_c),
        .o2_e_q   (n_o2_e_q),
        .o2_c_q   (n_o2_c_q),
        .o3_c_q   (n_o3_c_q),
        .mismatch (n_mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string tag, input logic e2, input logic e3);
        chk({tag, " s_o2_e_q"}, s_o2_e_q, e2);
        chk({tag, " s_o2_c_q"}, s_o2_c_q, e2);
        chk({tag, " s_o3_c_q"}, s_o3_c_q, e3);
        chk({tag, " n_o2_e_q"}, n_o2_e_q, e2);
        chk({tag, " n_o2_c_q"}, n_o2_c_q, e2);
        chk({tag, " n_o3_c_q"}, n_o3_c_q, e3);
    endtask

    // Apply inputs after a falling edge, then let one rising edge sample them.
    task automatic step(input logic a, input logic b, input logic c);
        i1 = a;
        i2 = b;
        i3 = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // {i3,i2,i1} counting 000..111; NAND2 covers i1,i2 only.
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset with all-ones inputs so reset values differ from data values.
        rst_n = 1'b0;
        i1 = 1'b1;
        i2 = 1'b1;
        i3 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_q("reset", 1'b1, 1'b1);
        chk("reset s_mismatch", s_mismatch, 1'b0);
        chk("reset n_mismatch", n_mismatch, 1'b0);
        chk("comb during reset o2_e", s_o2_e, 1'b0);
        chk("comb during reset o3_c", s_o3_c, 1'b0);

        // Latency: registers still hold reset value until the next edge.
        rst_n = 1'b1;
        #1;
        chk_q("pre-edge hold", 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk_q("latency 1->0", 1'b0, 1'b0);

        // Combinational sweep, 100 ps per vector.
        for (int k = 0; k < 8; k++) begin
            i1 = vecs[k].i1;
            i2 = vecs[k].i2;
            i3 = vecs[k].i3;
            #0.1;
            chk($sformatf("sweep%0d o2_e", k), s_o2_e, vecs[k].exp_o2);
            chk($sformatf("sweep%0d o2_c", k), s_o2_c, vecs[k].exp_o2);
            chk($sformatf("sweep%0d o3_c", k), s_o3_c, vecs[k].exp_o3);
            chk($sformatf("sweep%0d n_o3_c", k), n_o3_c, vecs[k].exp_o3);
        end

        // Registered path for distinct patterns.
        step(1'b0, 1'b1, 1'b1);
        chk_q("reg 011", 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk_q("reg 110", 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk_q("reg 101", 1'b1, 1'b1);
        chk("no mismatch s", s_mismatch, 1'b0);
        chk("no mismatch n", n_mismatch, 1'b0);

        // Forced disagreement between the NAND2 implementations.
        i1 = 1'b1;
        i2 = 1'b1;
        i3 = 1'b1;
        force dut_s.o2_e = 1'b1;
        force dut_n.o2_e = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("force s_mismatch", s_mismatch, 1'b1);
        chk("force n_mismatch", n_mismatch, 1'b1);
        release dut_s.o2_e;
        release dut_n.o2_e;
        @(posedge clk);
        @(negedge clk);
        chk("release s_mismatch sticky", s_mismatch, 1'b1);
        chk("release n_mismatch clears", n_mismatch, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("later s_mismatch sticky", s_mismatch, 1'b1);
        chk("later n_mismatch", n_mismatch, 1'b0);

        // Reset mid-run clears the sticky flag and reloads the registers.
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset s_mismatch", s_mismatch, 1'b0);
        chk_q("midreset", 1'b1, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_q("resume", 1'b0, 1'b0);
        chk("resume s_mismatch", s_mismatch, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
